// File: rtl/uart_parity_engine.sv
// Serial UART receive parity engine: assembles a data word LSB-first, accumulates
// parity as bits arrive, then checks the received parity bit against the latched mode.
module uart_parity_engine #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned MODE_W    = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [MODE_W-1:0]    i_mode,
   input  logic                 i_start,
   input  logic                 i_bit_valid,
   input  logic                 i_bit,
   input  logic                 i_parity_valid,
   output logic                 o_busy,
   output logic                 o_parity,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_done,
   output logic                 o_error
);

   localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DATA  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [MODE_W-1:0] MODE_EVEN  = MODE_W'(1);
   localparam logic [MODE_W-1:0] MODE_ODD   = MODE_W'(2);
   localparam logic [MODE_W-1:0] MODE_MARK  = MODE_W'(3);
   localparam logic [MODE_W-1:0] MODE_SPACE = MODE_W'(4);

   logic [1:0]           r_state,  w_state_nxt;
   logic [MODE_W-1:0]    r_mode,   w_mode_nxt;
   logic                 r_acc,    w_acc_nxt;
   logic [CNT_W-1:0]     r_count,  w_count_nxt;
   logic [DATA_BITS-1:0] r_data,   w_data_nxt;
   logic                 r_parity, w_parity_nxt;
   logic                 r_busy,   w_busy_nxt;
   logic                 r_done,   w_done_nxt;
   logic                 r_error,  w_error_nxt;

   logic w_acc_fin;
   logic w_par_en;
   logic w_exp_par;

   // Expected parity from the latched mode, including the bit being sampled now
   always_comb begin : par_decode
      w_acc_fin = r_acc ^ i_bit;
      w_par_en  = 1'b1;
      w_exp_par = 1'b0;
      case (r_mode)
         MODE_EVEN:  w_exp_par = w_acc_fin;
         MODE_ODD:   w_exp_par = ~w_acc_fin;
         MODE_MARK:  w_exp_par = 1'b1;
         MODE_SPACE: w_exp_par = 1'b0;
         default:    w_par_en  = 1'b0;
      endcase
   end

   always_comb begin : next_state
      w_state_nxt  = r_state;
      w_mode_nxt   = r_mode;
      w_acc_nxt    = r_acc;
      w_count_nxt  = r_count;
      w_data_nxt   = r_data;
      w_parity_nxt = r_parity;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_error_nxt  = r_error;

      case (r_state)
         S_DATA: begin
            if (i_bit_valid) begin
               w_acc_nxt = w_acc_fin;
               for (int unsigned i = 0; i < DATA_BITS; i++) begin
                  if (r_count == CNT_W'(i)) w_data_nxt[i] = i_bit;
               end
               if (r_count == CNT_W'(DATA_BITS - 1)) begin
                  if (w_par_en) begin
                     w_state_nxt  = S_CHECK;
                     w_parity_nxt = w_exp_par;
                  end else begin
                     w_state_nxt = S_DONE;
                     w_done_nxt  = 1'b1;
                     w_busy_nxt  = 1'b0;
                  end
               end else begin
                  w_count_nxt = r_count + CNT_W'(1);
               end
            end
         end
         S_CHECK: begin
            if (i_parity_valid) begin
               w_error_nxt = (i_bit != r_parity);
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: ;
      endcase

      // Start overrides any coincident strobe and aborts a frame in progress
      if (i_start) begin
         w_state_nxt  = S_DATA;
         w_mode_nxt   = i_mode;
         w_acc_nxt    = 1'b0;
         w_count_nxt  = '0;
         w_data_nxt   = '0;
         w_parity_nxt = 1'b0;
         w_error_nxt  = 1'b0;
         w_busy_nxt   = 1'b1;
         w_done_nxt   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_mode   <= '0;
         r_acc    <= 1'b0;
         r_count  <= '0;
         r_data   <= '0;
         r_parity <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_mode   <= w_mode_nxt;
         r_acc    <= w_acc_nxt;
         r_count  <= w_count_nxt;
         r_data   <= w_data_nxt;
         r_parity <= w_parity_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_error  <= w_error_nxt;
      end
   end

   assign o_busy   = r_busy;
   assign o_parity = r_parity;
   assign o_data   = r_data;
   assign o_done   = r_done;
   assign o_error  = r_error;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: 8-bit and 5-bit instances, directed frames.
module tb_uart_parity_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [2:0] mode8, mode5;
   logic       start8, start5, bv8, bv5, bit8, bit5, pv8, pv5;
   logic       busy8, par8, done8, err8;
   logic       busy5, par5, done5, err5;
   logic [7:0] data8;
   logic [4:0] data5;

   typedef struct packed {
      logic [8:0] data;
      logic       chk_par;
      logic       par;
      logic       err;
   } exp_t;

   exp_t q8[$];
   exp_t q5[$];
   exp_t e8, e5;

   int checks = 0;
   int errors = 0;

   uart_parity_engine #(.DATA_BITS(8), .MODE_W(3)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode8), .i_start(start8),
      .i_bit_valid(bv8), .i_bit(bit8), .i_parity_valid(pv8),
      .o_busy(busy8), .o_parity(par8), .o_data(data8), .o_done(done8), .o_error(err8)
   );

   uart_parity_engine #(.DATA_BITS(5), .MODE_W(3)) u_dut5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode5), .i_start(start5),
      .i_bit_valid(bv5), .i_bit(bit5), .i_parity_valid(pv5),
      .o_busy(busy5), .o_parity(par5), .o_data(data5), .o_done(done5), .o_error(err5)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: compare every completed frame against the scoreboard
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut8_unexpected_done: got done=1, expected no frame at %0t", $time);
         end else begin
            e8 = q8.pop_front();
            chk("dut8_data", 32'(data8), 32'(e8.data[7:0]));
            chk("dut8_error", 32'(err8), 32'(e8.err));
            if (e8.chk_par) chk("dut8_parity", 32'(par8), 32'(e8.par));
         end
      end
   end

   always @(negedge clk) begin
      if (done5 === 1'b1) begin
         if (q5.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut5_unexpected_done: got done=1, expected no frame at %0t", $time);
         end else begin
            e5 = q5.pop_front();
            chk("dut5_data", 32'(data5), 32'(e5.data[4:0]));
            chk("dut5_error", 32'(err5), 32'(e5.err));
            if (e5.chk_par) chk("dut5_parity", 32'(par5), 32'(e5.par));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic st, input logic bv, input logic b,
                        input logic pv, input logic [2:0] m);
      if (sel == 8) begin
         start8 = st; bv8 = bv; bit8 = b; pv8 = pv; mode8 = m;
      end else begin
         start5 = st; bv5 = bv; bit5 = b; pv5 = pv; mode5 = m;
      end
   endtask

   // Mode is driven to a junk value after start; the latched mode must be used
   task automatic do_start(input int sel, input logic [2:0] m);
      drive(sel, 1'b1, 1'b0, 1'b0, 1'b0, m);
      cyc();
      drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
   endtask

   task automatic send_bits(input int sel, input logic [8:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         drive(sel, 1'b0, 1'b1, d[i], 1'b0, 3'd3);
         cyc();
         drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
         if (i != n - 1) cyc();
      end
   endtask

   task automatic send_par(input int sel, input logic b);
      drive(sel, 1'b0, 1'b0, b, 1'b1, 3'd5);
      cyc();
      drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
   endtask

   task automatic push(input int sel, input logic [8:0] d, input logic cp,
                       input logic p, input logic er);
      exp_t e;
      e.data = d; e.chk_par = cp; e.par = p; e.err = er;
      if (sel == 8) q8.push_back(e);
      else q5.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      drive(5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      cyc(); cyc();
      chk("rst_busy", 32'(busy8), 32'(0));
      chk("rst_parity", 32'(par8), 32'(0));
      chk("rst_data", 32'(data8), 32'(0));
      chk("rst_done", 32'(done8), 32'(0));
      chk("rst_error", 32'(err8), 32'(0));
      chk("rst_data5", 32'(data5), 32'(0));
      rst_n = 1'b1;
      cyc();

      // Strobes in IDLE are ignored
      drive(8, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1);
      cyc(); cyc();
      drive(8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      chk("idle_data", 32'(data8), 32'(0));
      chk("idle_busy", 32'(busy8), 32'(0));
      chk("idle_error", 32'(err8), 32'(0));

      // Even, 0x03, parity 0: no error
      do_start(8, 3'd1);
      chk("even_busy", 32'(busy8), 32'(1));
      push(8, 9'h003, 1'b1, 1'b0, 1'b0);
      send_bits(8, 9'h003, 8);
      chk("even_check_parity", 32'(par8), 32'(0));
      drive(8, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      cyc();
      drive(8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      chk("check_ignores_bit", 32'(data8), 32'(8'h03));
      chk("check_no_done", 32'(done8), 32'(0));
      send_par(8, 1'b0);
      chk("even_done", 32'(done8), 32'(1));
      chk("even_busy_done", 32'(busy8), 32'(0));
      cyc();
      chk("even_done_single", 32'(done8), 32'(0));

      // Odd, 0xFF, parity 0: expected parity 1 so error
      do_start(8, 3'd2);
      push(8, 9'h0FF, 1'b1, 1'b1, 1'b1);
      send_bits(8, 9'h0FF, 8);
      send_par(8, 1'b0);
      chk("odd_done", 32'(done8), 32'(1));
      cyc(); cyc();
      chk("odd_error_hold", 32'(err8), 32'(1));

      // None, 0xA5: done right after the 8th bit; start clears the sticky error
      do_start(8, 3'd0);
      chk("start_clears_error", 32'(err8), 32'(0));
      push(8, 9'h0A5, 1'b0, 1'b0, 1'b0);
      send_bits(8, 9'h0A5, 8);
      chk("none_done", 32'(done8), 32'(1));
      chk("none_busy", 32'(busy8), 32'(0));
      cyc();
      chk("none_busy_after", 32'(busy8), 32'(0));
      chk("none_done_single", 32'(done8), 32'(0));

      // Abort after 3 bits with start coincident to a bit strobe
      do_start(8, 3'd1);
      send_bits(8, 9'h007, 3);
      drive(8, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
      cyc();
      drive(8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      chk("abort_data_clear", 32'(data8), 32'(0));
      chk("abort_busy", 32'(busy8), 32'(1));
      push(8, 9'h001, 1'b1, 1'b1, 1'b0);
      send_bits(8, 9'h001, 8);
      send_par(8, 1'b1);
      chk("abort_done", 32'(done8), 32'(1));

      // Start during DONE: done still pulses, then a fresh space-mode frame
      drive(8, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4);
      cyc();
      drive(8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
      chk("done_start_busy", 32'(busy8), 32'(1));
      chk("done_start_nodone", 32'(done8), 32'(0));
      push(8, 9'h00F, 1'b1, 1'b0, 1'b1);
      send_bits(8, 9'h00F, 8);
      send_par(8, 1'b1);
      chk("space_done", 32'(done8), 32'(1));
      cyc();

      // 5-bit instance: mark, space, invalid mode 6
      do_start(5, 3'd3);
      push(5, 9'h01F, 1'b1, 1'b1, 1'b1);
      send_bits(5, 9'h01F, 5);
      send_par(5, 1'b0);
      chk("mark5_done", 32'(done5), 32'(1));
      cyc();
      do_start(5, 3'd4);
      push(5, 9'h00A, 1'b1, 1'b0, 1'b0);
      send_bits(5, 9'h00A, 5);
      send_par(5, 1'b0);
      chk("space5_done", 32'(done5), 32'(1));
      cyc();
      do_start(5, 3'd6);
      push(5, 9'h015, 1'b0, 1'b0, 1'b0);
      send_bits(5, 9'h015, 5);
      chk("mode6_done", 32'(done5), 32'(1));
      cyc();

      // Async reset while waiting in CHECK
      do_start(8, 3'd1);
      send_bits(8, 9'h054, 8);
      chk("pre_rst_parity", 32'(par8), 32'(1));
      chk("pre_rst_data", 32'(data8), 32'(8'h54));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy8), 32'(0));
      chk("async_rst_data", 32'(data8), 32'(0));
      chk("async_rst_parity", 32'(par8), 32'(0));
      chk("async_rst_done", 32'(done8), 32'(0));
      cyc(); cyc();
      rst_n = 1'b1;
      cyc(); cyc();
      chk("post_rst_idle", 32'(busy8), 32'(0));
      do_start(8, 3'd1);
      push(8, 9'h000, 1'b1, 1'b0, 1'b0);
      send_bits(8, 9'h000, 8);
      send_par(8, 1'b0);
      chk("post_rst_done", 32'(done8), 32'(1));
      cyc(); cyc();

      chk("q8_drained", 32'(q8.size()), 32'(0));
      chk("q5_drained", 32'(q5.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_parity_engine.md
Name: uart_parity_engine

Overview:
Serial, parametrised successor to the combinational word parity checker. It accumulates parity bit-by-bit as the UART receiver samples data bits, and assembles the data word LSB-first. It then checks the received parity bit against the configured mode and reports a per-frame done and error result. It sits between the RX bit sampler and the RX frame/status logic.

Parameters:
DATA_BITS, 8, number of data bits per frame; legal range 5..9
MODE_W, 3, width of the parity mode select

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_mode  input  MODE_W  parity mode: 0 none, 1 even, 2 odd, 3 mark, 4 space; codes 5-7 are treated as none
i_start  input  1  start-of-frame strobe; clears the accumulator and latches i_mode
i_bit_valid  input  1  data-bit strobe, one cycle per sampled bit
i_bit  input  1  sampled serial bit; carries data during DATA and the parity bit during CHECK
i_parity_valid  input  1  received-parity-bit strobe
o_busy  output  1  high from the cycle after i_start until o_done
o_parity  output  1  expected parity bit; valid in CHECK and DONE
o_data  output  DATA_BITS  assembled word; bit 0 is the first bit received
o_done  output  1  single-cycle frame-complete pulse
o_error  output  1  parity mismatch flag; holds until the next i_start or reset

Behaviour:
- Reset (async assert, sync release): state IDLE; accumulator, bit count, o_data, o_parity, o_busy, o_done and o_error all 0.
- States: IDLE, DATA, CHECK, DONE. All outputs are registered.
- IDLE: i_start latches the mode, clears the accumulator, count and o_data, clears o_error, and moves to DATA; o_busy=1 from the next cycle. i_bit_valid and i_parity_valid are ignored.
- DATA, on each i_bit_valid:
  - acc <= acc ^ i_bit
  - o_data[count] <= i_bit
  - count <= count + 1
- DATA, on the bit with count == DATA_BITS-1:
  - latched mode none: go to DONE.
  - otherwise: go to CHECK, and o_parity is registered on the same edge.
- Expected parity bit: even = acc (final XOR); odd = ~acc; mark = 1; space = 0.
- CHECK, on i_parity_valid: o_error <= (i_bit != o_parity); go to DONE. i_bit_valid is ignored in CHECK.
- DONE: lasts exactly one cycle. o_done=1, o_busy=0, then IDLE.
  - o_done is asserted the cycle after the last qualifying strobe.
  - o_data, o_parity and o_error hold until the next i_start.
- i_start in DATA or CHECK aborts the frame: the accumulator and count are cleared, the mode is re-latched, the state stays/returns to DATA, and no o_done is produced for the aborted frame.
- i_start coincident with i_bit_valid or i_parity_valid: start wins and the strobe is discarded.
- i_start in the DONE cycle: o_done still pulses, and the next cycle is DATA with a fresh frame.
- Mode changes on i_mode after i_start have no effect until the next i_start.
- Async reset mid-frame: everything clears immediately and no o_done is produced; the block waits in IDLE.
- Count width is clog2(DATA_BITS+1). The count never exceeds DATA_BITS-1, so no wrap-around occurs.

Test Plan:
- DATA_BITS=8, even mode. Start, then bits 1,1,0,0,0,0,0,0 (0x03), then parity bit 0 -> o_parity=0, o_data=8'h03, o_done pulses one cycle after the parity strobe, o_error=0.
- Odd mode, data 0xFF, parity bit 0 -> o_parity=1, o_error=1. A following i_start clears o_error to 0.
- Mode none, data 0xA5 -> o_done one cycle after the 8th bit strobe with no parity strobe needed; o_error=0, o_busy low after DONE.
- Abort and strobe ordering:
  - Even mode: 3 bit strobes, then i_start together with i_bit_valid, then 8 bits of 0x01 and parity 1 -> single o_done, o_data=8'h01, o_error=0.
  - Strobes during IDLE change nothing.
- DATA_BITS=5: mark mode with data 5'h1F and parity bit 0 -> o_error=1; space mode with parity bit 0 -> o_error=0. Invalid mode code 6 behaves as none (done after 5 bits).
- Reset asserted mid-CHECK -> all outputs 0 asynchronously, no o_done. After release, a fresh even-mode frame of 0x00 with parity 0 -> o_error=0.
